// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by both the SIPO receiver and PISO side.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register: valid/ready handshake plus sticky overrun flag.
module sipo_hold_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    input  logic             clear_ovr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             can_load;

    // A slot frees up on the same edge the held word is accepted.
    assign can_load = !valid_q || ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clear_ovr_i) begin
            ovr_d = 1'b0;
        end
        if (load_i) begin
            if (can_load) begin
                data_d  = word_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver, LSB first, with start-of-frame marker.
module sipo_rx
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             start,
    input  logic             out_ready,
    input  logic             clear_ovr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] ins_d;
    logic             done_d;

    // Current shift contents with the incoming bit placed at position cnt_q.
    always_comb begin
        ins_d = shreg_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) begin
                ins_d[i] = serial_in;
            end
        end
    end

    assign done_d = (state_q == SHIFT) && shift_en && !start && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (shift_en) begin
            if (start) begin
                state_q <= SHIFT;
                cnt_q   <= CW'(1);
                shreg_q <= {{(WIDTH-1){1'b0}}, serial_in};
            end else if (state_q == SHIFT) begin
                if (cnt_q == LAST) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    shreg_q <= '0;
                end else begin
                    cnt_q   <= cnt_q + CW'(1);
                    shreg_q <= ins_d;
                end
            end
        end
    end

    sipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (done_d),
        .word_i     (ins_d),
        .ready_i    (out_ready),
        .clear_ovr_i(clear_ovr),
        .data_o     (parallel_out),
        .valid_o    (out_valid),
        .overrun_o  (overrun)
    );

    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed-vector bench for sipo_rx at WIDTH=4.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_in = 1'b0;
    logic       shift_en = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_ovr = 1'b0;
    logic [3:0] parallel_out;
    logic       out_valid;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    sipo_rx #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .shift_en    (shift_en),
        .start       (start),
        .out_ready   (out_ready),
        .clear_ovr   (clear_ovr),
        .parallel_out(parallel_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Drive one bit at a falling edge, consume it on the rising edge,
    // return at the next falling edge with enables dropped.
    task automatic send_bit(input logic b, input logic st);
        serial_in = b;
        start     = st;
        shift_en  = 1'b1;
        @(negedge clk);
        shift_en  = 1'b0;
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            send_bit(w[i], i == 0);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({parallel_out, out_valid, busy, overrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want 0000000",
                     {parallel_out, out_valid, busy, overrun});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_bit(1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if ({parallel_out, out_valid, busy} !== {4'b1010, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_word: got %b/%b/%b want 1010/1/0",
                     parallel_out, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold: valid got %b want 1", out_valid);
        end
        accept();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] w;
        w = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            send_bit(w[i], i == 0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL gap_busy bit%0d gap%0d: got %b want 1",
                                 i, g, busy);
                    end
                    @(negedge clk);
                end
            end
        end
        checks++;
        if ({parallel_out, out_valid, busy} !== {4'b1010, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL gap_word: got %b/%b/%b want 1010/1/0",
                     parallel_out, out_valid, busy);
        end
        accept();
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        send_word(4'b1010);
        send_word(4'b0110);
        checks++;
        if ({parallel_out, out_valid, overrun} !== {4'b1010, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL overrun_set: got %b/%b/%b want 1010/1/1",
                     parallel_out, out_valid, overrun);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        checks++;
        if ({overrun, parallel_out} !== {1'b0, 4'b1010}) begin
            errors++;
            $display("FAIL overrun_clear: got %b/%b want 0/1010",
                     overrun, parallel_out);
        end
        accept();
    endtask

    task automatic test_set_wins();
        out_ready = 1'b0;
        send_word(4'b0011);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, i == 0);
        end
        clear_ovr = 1'b1;
        send_bit(1'b1, 1'b0);
        clear_ovr = 1'b0;
        checks++;
        if ({overrun, parallel_out} !== {1'b1, 4'b0011}) begin
            errors++;
            $display("FAIL set_wins: got %b/%b want 1/0011",
                     overrun, parallel_out);
        end
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        accept();
    endtask

    task automatic test_abort();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %b want 1", busy);
        end
        send_word(4'b1100);
        checks++;
        if ({parallel_out, out_valid, overrun, busy} !==
            {4'b1100, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_word: got %b/%b/%b/%b want 1100/1/0/0",
                     parallel_out, out_valid, overrun, busy);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        out_ready = 1'b1;
        send_word(4'hA);
        checks++;
        if ({parallel_out, out_valid} !== {4'hA, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b want a/1",
                     parallel_out, out_valid);
        end
        out_ready = 1'b0;
        w = 4'h5;
        for (int i = 0; i < 3; i++) begin
            send_bit(w[i], i == 0);
        end
        out_ready = 1'b1;
        send_bit(w[3], 1'b0);
        checks++;
        if ({parallel_out, out_valid, overrun} !== {4'h5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got %h/%b/%b want 5/1/0",
                     parallel_out, out_valid, overrun);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_word(4'h9);
        send_word(4'h6);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, i == 0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({parallel_out, out_valid, busy, overrun} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got %b want 0000000",
                     {parallel_out, out_valid, busy, overrun});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1, 1'b0);
        end
        checks++;
        if ({busy, out_valid, parallel_out} !== 6'b0) begin
            errors++;
            $display("FAIL nostart_ignored: got %b/%b/%b want 0/0/0000",
                     busy, out_valid, parallel_out);
        end
        send_word(4'b1001);
        checks++;
        if ({parallel_out, out_valid} !== {4'b1001, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_word: got %b/%b want 1001/1",
                     parallel_out, out_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_set_wins();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
